// File: rtl/block_ram_arb_pkg.sv
// Shared types and helpers for the two-port block RAM arbiter.
package block_ram_arb_pkg;

    // Which requester owns an in-flight response.
    typedef enum logic {PORT_A, PORT_B} ram_port_t;

    // Bit positions of the two requesters inside req/gnt vectors.
    localparam int unsigned GNT_A = 0;
    localparam int unsigned GNT_B = 1;

    // Widest byte-enable vector is_req() accepts; callers zero-extend into it.
    localparam int unsigned MAX_WE = 64;

    // A requester is active when it reads, writes any byte, or both.
    function automatic logic is_req(input logic re, input logic [MAX_WE-1:0] we);
        return re | (|we);
    endfunction

endpackage

// File: rtl/block_ram_arbiter_rr_pick2.sv
// Two-way grant pick with a last-winner register for round-robin fairness.
module rr_pick2
    import block_ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);

    // 1 = B won the most recent contested cycle; reset value hands the first contest to A.
    logic last_b;

    // Grant is combinational; nothing is granted while reset is held.
    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (rr && !last_b) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Winner memory only moves on contested cycles so lone requests do not skew fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (req == 2'b11) begin
            last_b <= gnt[GNT_B];
        end
    end

    // Sanity: at most one winner, and only a requester can win.
    gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    gnt_has_req: assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == 2'b00);

endmodule

// File: rtl/block_ram_arbiter.sv
// Shares one single-port block RAM between requesters A and B, one access per cycle.
module block_ram_arbiter
    import block_ram_arb_pkg::*;
#(
    parameter int unsigned abits  = 8,
    parameter int unsigned dbytes = 4,
    parameter int unsigned blen   = 8,
    parameter bit          rr     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    a_re,
    input  logic [dbytes-1:0]       a_we,
    input  logic [abits-1:0]        a_addr,
    input  logic [dbytes*blen-1:0]  a_wdata,
    output logic                    a_ready,
    output logic                    a_valid,
    output logic [dbytes*blen-1:0]  a_rdata,

    input  logic                    b_re,
    input  logic [dbytes-1:0]       b_we,
    input  logic [abits-1:0]        b_addr,
    input  logic [dbytes*blen-1:0]  b_wdata,
    output logic                    b_ready,
    output logic                    b_valid,
    output logic [dbytes*blen-1:0]  b_rdata,

    output logic [dbytes-1:0]       ram_we,
    output logic [abits-1:0]        ram_addr,
    output logic [dbytes*blen-1:0]  ram_wdata,
    input  logic [dbytes*blen-1:0]  ram_rdata
);

    localparam int unsigned dbits = dbytes * blen;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             resp_pend;
    ram_port_t        resp_sel;
    logic [abits-1:0] addr_q;
    logic [dbits-1:0] a_hold;
    logic [dbits-1:0] b_hold;

    // Request detection: a read, any byte write, or both counts as one access.
    always_comb begin
        req        = 2'b00;
        req[GNT_A] = is_req(a_re, MAX_WE'(a_we));
        req[GNT_B] = is_req(b_re, MAX_WE'(b_we));
    end

    rr_pick2 u_pick (
        .clk (clk),
        .rst (rst),
        .req (req),
        .rr  (rr),
        .gnt (gnt)
    );

    assign a_ready = gnt[GNT_A];
    assign b_ready = gnt[GNT_B];

    // RAM drive: follow the granted port, otherwise park on the last granted address.
    always_comb begin
        ram_we    = '0;
        ram_addr  = addr_q;
        ram_wdata = '0;
        if (gnt[GNT_A]) begin
            ram_we    = a_we;
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
        end else if (gnt[GNT_B]) begin
            ram_we    = b_we;
            ram_addr  = b_addr;
            ram_wdata = b_wdata;
        end
    end

    // Parked address copy keeps the RAM read port quiet between grants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (|gnt) begin
            addr_q <= ram_addr;
        end
    end

    // Response pipeline: remember who was granted so next cycle's RAM data goes to them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_pend <= 1'b0;
            resp_sel  <= PORT_A;
        end else begin
            resp_pend <= |gnt;
            resp_sel  <= gnt[GNT_B] ? PORT_B : PORT_A;
        end
    end

    assign a_valid = resp_pend && (resp_sel == PORT_A);
    assign b_valid = resp_pend && (resp_sel == PORT_B);

    // Hold registers capture each port's response word so it survives the other port's traffic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_hold <= '0;
            b_hold <= '0;
        end else begin
            if (a_valid) begin
                a_hold <= ram_rdata;
            end
            if (b_valid) begin
                b_hold <= ram_rdata;
            end
        end
    end

    // During the response pulse the RAM output is forwarded directly; afterwards the hold copy.
    assign a_rdata = a_valid ? ram_rdata : a_hold;
    assign b_rdata = b_valid ? ram_rdata : b_hold;

    // Only one response can be in flight, so the two valids never coincide.
    valid_excl: assert property (@(posedge clk) disable iff (rst) !(a_valid && b_valid));

endmodule
